// File: rtl/mips_encode.sv
// mips_encode
//   Encodes arithmetic/logical MIPS requests (add, sub, and, or, nor, xor,
//   addi, andi, ori, xori) into 32-bit instruction words. Requests enter on a
//   valid/ready handshake into a DEPTH-entry FIFO; encoded words leave on a
//   valid/ready handshake tagged with a sequential word address.
//
// Ports
//   clock        rising-edge clock
//   reset        synchronous, active-low reset
//   in_valid     request present
//   in_ready     encoder can accept a request (FIFO not full)
//   op           0 add,1 sub,2 and,3 or,4 nor,5 xor,6 addi,7 andi,8 ori,9 xori
//   dst          rd (R-type) / rt (I-type)
//   src1         rs
//   src2         rt (R-type only)
//   imm          immediate (I-type only)
//   out_valid    out_instr/out_addr valid
//   out_ready    consumer takes the word
//   out_instr    encoded instruction at FIFO head, 0 when empty
//   out_addr     BASE_ADDR + 4*instr_count
//   instr_count  words popped since reset (wrapping)
//   except       one-cycle pulse after an illegal op was accepted
//   err_flag     sticky illegal-op indicator
module mips_encode #(
  parameter int              DEPTH     = 4,
  parameter int              CNT_W     = 16,
  parameter logic [31:0]     BASE_ADDR = 32'h0040_0000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [4:0]       dst,
  input  logic [4:0]       src1,
  input  logic [4:0]       src2,
  input  logic [15:0]      imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [31:0]      out_addr,
  output logic [CNT_W-1:0] instr_count,
  output logic             except,
  output logic             err_flag
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]   OCC_ONE = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   OCC_MAX = (PTR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [31:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   occ;

  logic [31:0] enc_word;
  logic        enc_legal;
  logic        accept;
  logic        push;
  logic        pop;
  logic [31:0] cnt_ext;

  // Combinational encoder; the result is only captured when a legal request
  // is accepted.
  always_comb begin
    enc_word  = 32'h0;
    enc_legal = 1'b1;
    case (op)
      4'd0: enc_word = {6'h00, src1, src2, dst, 5'b0, 6'h20};
      4'd1: enc_word = {6'h00, src1, src2, dst, 5'b0, 6'h22};
      4'd2: enc_word = {6'h00, src1, src2, dst, 5'b0, 6'h24};
      4'd3: enc_word = {6'h00, src1, src2, dst, 5'b0, 6'h25};
      4'd4: enc_word = {6'h00, src1, src2, dst, 5'b0, 6'h27};
      4'd5: enc_word = {6'h00, src1, src2, dst, 5'b0, 6'h26};
      4'd6: enc_word = {6'h08, src1, dst, imm};
      4'd7: enc_word = {6'h0c, src1, dst, imm};
      4'd8: enc_word = {6'h0d, src1, dst, imm};
      4'd9: enc_word = {6'h0e, src1, dst, imm};
      default: enc_legal = 1'b0;
    endcase
  end

  // in_ready depends only on occupancy: a full FIFO refuses even if the
  // consumer is popping in the same cycle.
  assign in_ready  = (occ < OCC_MAX);
  assign out_valid = (occ != '0);
  assign accept    = in_valid & in_ready;
  assign push      = accept & enc_legal;
  assign pop       = out_valid & out_ready;

  assign out_instr = out_valid ? mem[rd_ptr] : 32'h0;
  assign cnt_ext   = 32'(instr_count);
  assign out_addr  = BASE_ADDR + (cnt_ext << 2);

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      occ         <= '0;
      instr_count <= '0;
      except      <= 1'b0;
      err_flag    <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= enc_word;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr      <= rd_ptr + PTR_ONE;
        instr_count <= instr_count + CNT_ONE;
      end
      if (push && !pop)
        occ <= occ + OCC_ONE;
      else if (pop && !push)
        occ <= occ - OCC_ONE;
      // Illegal ops consume the handshake but leave the FIFO untouched.
      except <= accept & ~enc_legal;
      if (accept && !enc_legal)
        err_flag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mips_encode.sv
module tb_mips_encode;

  localparam int          DEPTH = 4;
  localparam int          CNT_W = 16;
  localparam logic [31:0] BASE  = 32'h0040_0000;

  logic             clock;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [4:0]       dst;
  logic [4:0]       src1;
  logic [4:0]       src2;
  logic [15:0]      imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic [31:0]      out_addr;
  logic [CNT_W-1:0] instr_count;
  logic             except;
  logic             err_flag;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [31:0]      m_q[$];
  logic [CNT_W-1:0] m_count;
  logic             m_err;
  logic             m_exc;

  mips_encode #(.DEPTH(DEPTH), .CNT_W(CNT_W), .BASE_ADDR(BASE)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .dst(dst), .src1(src1), .src2(src2), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr),
    .instr_count(instr_count), .except(except), .err_flag(err_flag)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Encoding rules as field arithmetic.
  function automatic logic [31:0] ref_encode(input int o, input int d, input int s1,
                                             input int s2, input int im,
                                             output bit legal);
    int funct[6] = '{32'h20, 32'h22, 32'h24, 32'h25, 32'h27, 32'h26};
    int opc[4]   = '{32'h08, 32'h0c, 32'h0d, 32'h0e};
    legal = 1;
    if (o <= 5)      return 32'((s1 << 21) + (s2 << 16) + (d << 11) + funct[o]);
    else if (o <= 9) return 32'((opc[o-6] << 26) + (s1 << 21) + (d << 16) + (im & 32'hffff));
    legal = 0;
    return 32'h0;
  endfunction

  // Advance one clock, updating the model from the inputs presented this cycle.
  task automatic tick();
    bit acc, pp, lg;
    logic [31:0] w;
    if (!reset) begin
      m_q.delete();
      m_count = '0;
      m_err   = 1'b0;
      m_exc   = 1'b0;
    end else begin
      acc = in_valid && (m_q.size() < DEPTH);
      pp  = (m_q.size() > 0) && out_ready;
      w   = ref_encode(int'(op), int'(dst), int'(src1), int'(src2), int'(imm), lg);
      m_exc = acc && !lg;
      if (m_exc) m_err = 1'b1;
      if (pp) begin
        void'(m_q.pop_front());
        m_count = m_count + 1'b1;
      end
      if (acc && lg) m_q.push_back(w);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic set_req(input int o, input int d, input int s1, input int s2, input int im);
    op = 4'(o); dst = 5'(d); src1 = 5'(s1); src2 = 5'(s2); imm = 16'(im);
  endtask

  task automatic rand_req(input bit allow_illegal);
    set_req(allow_illegal ? $urandom_range(0, 15) : $urandom_range(0, 9),
            $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
            $urandom_range(0, 65535));
  endtask

  task automatic test_reset();
    in_valid = 1'b0; out_ready = 1'b0; set_req(0, 0, 0, 0, 0);
    do_reset();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    tests++; if (out_instr !== 32'h0) begin fails++; $display("FAIL reset_out_instr: got %h want 0", out_instr); end
    tests++; if (out_addr !== BASE) begin fails++; $display("FAIL reset_out_addr: got %h want %h", out_addr, BASE); end
    tests++; if (instr_count !== '0 || except !== 1'b0 || err_flag !== 1'b0) begin
      fails++; $display("FAIL reset_cnt_flags: got %0d/%b/%b want 0/0/0", instr_count, except, err_flag);
    end
  endtask

  task automatic test_rtype();
    do_reset();
    set_req(0, 3, 1, 2, 16'h1234); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL rtype_latency: got %b want 1", out_valid); end
    tests++; if (out_instr !== 32'h00221820) begin fails++; $display("FAIL rtype_add: got %h want 00221820", out_instr); end
    tests++; if (out_addr !== 32'h00400000) begin fails++; $display("FAIL rtype_addr: got %h want 00400000", out_addr); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tests++; if (instr_count !== 16'd1) begin fails++; $display("FAIL rtype_count: got %0d want 1", instr_count); end
    tests++; if (out_valid !== 1'b0 || out_addr !== 32'h00400004) begin
      fails++; $display("FAIL rtype_after_pop: got %b/%h want 0/00400004", out_valid, out_addr);
    end
  endtask

  task automatic test_itype();
    do_reset();
    in_valid = 1'b1;
    set_req(6, 8, 9, 31, 16'hFFFF); tick();
    set_req(9, 5, 4, 7, 16'h00F0);  tick();
    in_valid = 1'b0;
    tests++; if (out_instr !== 32'h2128FFFF) begin fails++; $display("FAIL itype_addi: got %h want 2128FFFF", out_instr); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    tests++; if (out_instr !== 32'h388500F0) begin fails++; $display("FAIL itype_xori: got %h want 388500F0", out_instr); end
    tests++; if (out_addr !== 32'h00400004) begin fails++; $display("FAIL itype_addr: got %h want 00400004", out_addr); end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_w[5];
    bit lg;
    int popped = 0;
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_req(i, i + 1, i + 2, i + 3, 16'h100 + i);
      exp_w[i] = ref_encode(i, i + 1, i + 2, i + 3, 16'h100 + i, lg);
      in_valid = 1'b1;
      tests++; if (in_ready !== (i < 4)) begin fails++; $display("FAIL bp_in_ready_%0d: got %b want %b", i, in_ready, (i < 4)); end
      if (i < 4) tick();
    end
    // 5th request stays presented; it should enter once a slot frees.
    out_ready = 1'b1;
    for (int c = 0; c < 12 && popped < 5; c++) begin
      if (out_valid) begin
        tests++; if (out_instr !== exp_w[popped] || out_addr !== BASE + 32'(4 * popped)) begin
          fails++; $display("FAIL bp_word_%0d: got %h@%h want %h@%h", popped, out_instr, out_addr,
                            exp_w[popped], BASE + 32'(4 * popped));
        end
        popped++;
      end
      if (in_valid && m_q.size() < DEPTH) begin
        tick(); in_valid = 1'b0;
      end else tick();
    end
    out_ready = 1'b0; in_valid = 1'b0;
    tests++; if (popped != 5) begin fails++; $display("FAIL bp_drain_count: got %0d want 5", popped); end
    tests++; if (instr_count !== m_count) begin fails++; $display("FAIL bp_instr_count: got %0d want %0d", instr_count, m_count); end
  endtask

  task automatic test_back_to_back();
    logic [CNT_W-1:0] prev;
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1;
    rand_req(0); tick();
    for (int i = 0; i < 20; i++) begin
      prev = instr_count;
      rand_req(0); tick();
      tests++; if (out_valid !== 1'b1 || in_ready !== 1'b1 || instr_count !== prev + 1'b1) begin
        fails++; $display("FAIL b2b_stream_%0d: got v%b r%b cnt%0d want v1 r1 cnt%0d", i, out_valid, in_ready, instr_count, prev + 1'b1);
      end
      tests++; if (out_instr !== m_q[0]) begin fails++; $display("FAIL b2b_word_%0d: got %h want %h", i, out_instr, m_q[0]); end
    end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_illegal();
    logic [CNT_W-1:0] c0;
    do_reset();
    c0 = instr_count;
    set_req(12, 1, 2, 3, 4); in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL illegal_enqueued: got %b want 0", out_valid); end
    tests++; if (except !== 1'b1 || err_flag !== 1'b1) begin fails++; $display("FAIL illegal_pulse: got %b/%b want 1/1", except, err_flag); end
    tick();
    tests++; if (except !== 1'b0 || err_flag !== 1'b1) begin fails++; $display("FAIL illegal_after: got %b/%b want 0/1", except, err_flag); end
    tests++; if (instr_count !== c0) begin fails++; $display("FAIL illegal_count: got %0d want %0d", instr_count, c0); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin rand_req(0); tick(); end
    set_req(15, 0, 0, 0, 0); tick();
    in_valid = 1'b0; out_ready = 1'b1; tick();
    reset = 1'b0; in_valid = 1'b1; rand_req(0);
    tick();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL midreset_hs: got %b/%b want 0/1", out_valid, in_ready); end
    tests++; if (instr_count !== '0 || err_flag !== 1'b0 || out_addr !== BASE) begin
      fails++; $display("FAIL midreset_state: got %0d/%b/%h want 0/0/%h", instr_count, err_flag, out_addr, BASE);
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_i;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      rand_req(1);
      tick();
      exp_i = (m_q.size() > 0) ? m_q[0] : 32'h0;
      tests++;
      if (out_valid !== (m_q.size() > 0) || in_ready !== (m_q.size() < DEPTH) || out_instr !== exp_i ||
          out_addr !== BASE + {14'b0, m_count, 2'b00} || instr_count !== m_count ||
          except !== m_exc || err_flag !== m_err) begin
        fails++;
        $display("FAIL random_%0d: got v%b r%b i%h a%h c%0d x%b e%b want v%b r%b i%h a%h c%0d x%b e%b", i,
                 out_valid, in_ready, out_instr, out_addr, instr_count, except, err_flag,
                 (m_q.size() > 0), (m_q.size() < DEPTH), exp_i, BASE + {14'b0, m_count, 2'b00},
                 m_count, m_exc, m_err);
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_req(0, 0, 0, 0, 0);
    m_count = '0; m_err = 1'b0; m_exc = 1'b0;
    test_reset();
    test_rtype();
    test_itype();
    test_backpressure();
    test_back_to_back();
    test_illegal();
    test_reset_midstream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
